credit_rx_buffer: RTL and testbench
===================================

// Module: credit_rx_buffer
// PURPOSE
//   Receiving end of a router output link: accepts flits (data + valid) from a
//   router output port, holds them in a DEPTH-entry FIFO and returns one credit
//   pulse per flit drained. Sits between a Router output (oN/voN/ciN) and a
//   consumer (PE or next stage), so the sender never overruns the buffer.
// PARAMETERS
//   WIDTH   20  flit width in bits; flit content is opaque to this block
//   DEPTH   4   FIFO entries; equals the sender's initial credit count; power of 2, >=2
//   AW      2   pointer width, log2(DEPTH)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   RST        in   1      asynchronous reset, active-low
//   in         in   WIDTH  incoming flit from the router output
//   vi         in   1      in holds a valid flit this cycle
//   co         out  1      credit return to the sender, 1-cycle pulse per freed slot
//   dout       out  WIDTH  head-of-FIFO flit
//   dout_valid out  1      FIFO non-empty; dout is valid
//   dout_ready in   1      consumer accepts dout this cycle
//   count      out  AW+1   current occupancy, 0..DEPTH
//   overflow   out  1      sticky error: flit arrived with no free slot
// BEHAVIOUR
//   Reset (RST=0, async): wr_ptr=rd_ptr=0, count=0, co=0, dout_valid=0,
//     overflow=0; storage contents are don't-care; dout is don't-care while
//     dout_valid=0.
//   push = vi & (count<DEPTH | pop); pop = dout_valid & dout_ready.
//   Push writes in at wr_ptr, wr_ptr+1 (mod DEPTH). Pop advances rd_ptr+1 (mod DEPTH).
//   count' = count + push - pop; both same cycle -> count unchanged.
//   Full (count==DEPTH) with simultaneous pop: push is accepted; the freed slot is reused.
//   Full with no pop and vi=1: flit dropped, pointers/count unchanged,
//     overflow set to 1 next edge and held until reset.
//   Empty with vi=1 and dout_ready=1: no bypass; the flit is written, so pop=0 that cycle.
//   Latency: flit pushed at edge N -> dout_valid=1, dout=flit after edge N.
//     Min in->out latency is 1 cycle. dout is first-word-fall-through from head entry.
//   Credit: co is registered, co <= pop; one pulse per popped flit, one cycle
//     after the pop edge. Back-to-back pops give a continuous co=1 train.
//   Ordering: strict FIFO; no reordering or duplication; dropped flits are never output.
//   dout/dout_valid change only on clock edges (driven from registers/pointers).
//   Reset mid-operation: all stored flits discarded, no credits issued for
//     them; the sender must also reset its credit counter to DEPTH.
//   Credit conservation: sender credits + count + pending co == DEPTH at every
//     cycle boundary when the sender is well-behaved.
// TESTING
//   1 Reset: hold RST=0 with vi=1 -> co=0, dout_valid=0, count=0, overflow=0.
//   2 Single flit: vi=1,in=20'hA5A5A for 1 cycle, dout_ready=0 -> next cycle
//     dout_valid=1, dout=20'hA5A5A, count=1; then ready=1 one cycle -> co=1
//     exactly one cycle later, count=0.
//   3 Fill/order: push 20'h00001..20'h00004, ready=0 -> count=4; drain with
//     ready=1 -> dout 1,2,3,4 in order, four co pulses, pointers wrap to 0.
//   4 Overflow: full + vi=1,in=20'hFFFFF, ready=0 -> overflow=1 sticky,
//     count=4, 20'hFFFFF never appears on dout.
//   5 Full + push + pop same cycle: count stays 4, overflow stays 0, new flit
//     appears after the 3 older ones, one co pulse.
//   6 Streaming: vi=1 and ready=1 for 50 cycles with incrementing data -> count
//     stays at 1 after the first cycle, output matches input exactly, 49 co pulses;
//     reset asserted mid-stream clears count and dout_valid immediately.

Source files
------------

// File: rtl/credit_rx_buffer.sv
// Credit-based receive buffer for a router output link.
// Holds flits in a FIFO and returns one credit per flit drained.
module credit_rx_buffer #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] in,
  input  logic             vi,
  output logic             co,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees the head slot in the same cycle, so a full
  // buffer may still accept a flit when the consumer drains.
  assign pop  = ~empty & dout_ready;
  assign push = vi & (~full | pop);
  assign drop = vi & full & ~pop;

  // Next-state for pointers, occupancy, credit and error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    co_d     = pop;
    ovf_d    = ovf_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Control state; stored flits are discarded on reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  // Flit storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = ~empty;
  assign count      = count_q;
  assign co         = co_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_credit_rx_buffer.sv
// Directed self-checking bench for credit_rx_buffer.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_credit_rx_buffer;

  logic        clk;
  logic        RST;
  logic [19:0] in;
  logic        vi;
  logic        co;
  logic [19:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  count;
  logic        overflow;

  int ntests;
  int nfail;
  int pulses;

  credit_rx_buffer #(.WIDTH(20), .DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .RST        (RST),
    .in         (in),
    .vi         (vi),
    .co         (co),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    pulses = 0;
    RST = 1'b0;
    vi = 1'b1;
    in = 20'h12345;
    dout_ready = 1'b0;

    // 1 reset held with vi=1
    tick();
    tick();
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_dv", 32'(dout_valid), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    vi = 1'b0;
    RST = 1'b1;
    tick();
    chk("idle_cnt", 32'(count), 32'd0);

    // 2 single flit
    vi = 1'b1;
    in = 20'hA5A5A;
    tick();
    vi = 1'b0;
    chk("s_dv", 32'(dout_valid), 32'd1);
    chk("s_dout", 32'(dout), 32'hA5A5A);
    chk("s_cnt", 32'(count), 32'd1);
    chk("s_co0", 32'(co), 32'd0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("s_co1", 32'(co), 32'd1);
    chk("s_cnt0", 32'(count), 32'd0);
    chk("s_dv0", 32'(dout_valid), 32'd0);
    tick();
    chk("s_co_end", 32'(co), 32'd0);

    // 3 fill and drain in order
    for (int i = 1; i <= 4; i++) begin
      vi = 1'b1;
      in = 20'(i);
      tick();
    end
    vi = 1'b0;
    chk("f_cnt4", 32'(count), 32'd4);
    chk("f_dv", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("f_dout", 32'(dout), 32'(i));
      tick();
      chk("f_co", 32'(co), 32'd1);
    end
    dout_ready = 1'b0;
    chk("f_cnt0", 32'(count), 32'd0);
    tick();
    chk("f_co_end", 32'(co), 32'd0);

    // 4 overflow while full
    for (int i = 0; i < 4; i++) begin
      vi = 1'b1;
      in = 20'(32'h11 + i);
      tick();
    end
    vi = 1'b1;
    in = 20'hFFFFF;
    tick();
    vi = 1'b0;
    chk("o_ovf", 32'(overflow), 32'd1);
    chk("o_cnt", 32'(count), 32'd4);
    tick();
    chk("o_sticky", 32'(overflow), 32'd1);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("o_dout", 32'(dout), 32'h11 + i);
      tick();
    end
    dout_ready = 1'b0;
    chk("o_dv0", 32'(dout_valid), 32'd0);
    chk("o_sticky2", 32'(overflow), 32'd1);
    RST = 1'b0;
    #1;
    chk("o_rst_ovf", 32'(overflow), 32'd0);
    chk("o_rst_cnt", 32'(count), 32'd0);
    RST = 1'b1;
    tick();

    // 5 full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      vi = 1'b1;
      in = 20'(32'h21 + i);
      tick();
    end
    chk("b_full", 32'(count), 32'd4);
    vi = 1'b1;
    in = 20'h00025;
    dout_ready = 1'b1;
    tick();
    vi = 1'b0;
    dout_ready = 1'b0;
    chk("b_cnt", 32'(count), 32'd4);
    chk("b_ovf", 32'(overflow), 32'd0);
    chk("b_co", 32'(co), 32'd1);
    chk("b_head", 32'(dout), 32'h22);
    tick();
    chk("b_co0", 32'(co), 32'd0);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b_dout", 32'(dout), 32'h22 + i);
      tick();
    end
    dout_ready = 1'b0;
    chk("b_empty", 32'(dout_valid), 32'd0);
    tick();

    // 6 streaming, then reset mid-stream
    vi = 1'b1;
    dout_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      in = 20'(32'h100 + k);
      tick();
      chk("st_cnt", 32'(count), 32'd1);
      chk("st_dout", 32'(dout), 32'h100 + k);
      chk("st_co", 32'(co), (k > 0) ? 32'd1 : 32'd0);
      if (co) pulses++;
    end
    chk("st_pulses", 32'(pulses), 32'd49);
    RST = 1'b0;
    #1;
    chk("st_rst_cnt", 32'(count), 32'd0);
    chk("st_rst_dv", 32'(dout_valid), 32'd0);
    chk("st_rst_co", 32'(co), 32'd0);
    vi = 1'b0;
    dout_ready = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk("post_cnt", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
